cs_clk_event_sched: RTL and testbench

//  Schedules mission-clock events of a target partition onto its single fringe put/get channel.

---
 rtl/cs_sched_pkg.sv | 22 ++
 rtl/cs_clk_event_sched_if.sv | 25 ++
 rtl/cs_rr_arbiter.sv | 32 +++
 rtl/cs_clk_event_sched.sv | 174 +++++++++++++++++
 tb/tb_cs_clk_event_sched.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cs_sched_pkg.sv
// Shared types and constants for the mission-clock event scheduler.
// Holds the FSM state enum, default watchdog limit and stats counter width.
package cs_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUT  = 3'd1,
    GET  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } cs_sched_state_e;

  localparam int WDOG_MAX_DEFAULT = 10000;
  localparam int WDOG_W_DEFAULT   = 16;
  localparam int STATS_W          = 16;

  // Round-robin successor of an index, wrapping n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cs_clk_event_sched_if.sv
// Fringe put/get channel between the scheduler (master) and the transport glue (slave).
interface cs_clk_event_sched_if #(
  parameter int IDX_W = 2
);
  // Handshake: put_req_o/get_req_o rise with a stable index and stay high until
  // the slave answers with put_done_i/get_valid_i; the transfer completes on the
  // clock edge where request and answer are both high. Answers seen without a
  // matching request are ignored.
  logic             put_req_o;
  logic [IDX_W-1:0] put_idx_o;
  logic             put_done_i;
  logic             get_req_o;
  logic [IDX_W-1:0] get_idx_o;
  logic             get_valid_i;

  modport master (
    output put_req_o, put_idx_o, get_req_o, get_idx_o,
    input  put_done_i, get_valid_i
  );

  modport slave (
    input  put_req_o, put_idx_o, get_req_o, get_idx_o,
    output put_done_i, get_valid_i
  );
endinterface

// File: rtl/cs_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module cs_rr_arbiter #(
  parameter int N_CLK = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CLK-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_CLK-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] j;
    found = 1'b0;
    j     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < N_CLK; k++) begin
      j = IDX_W'((int'(ptr_i) + k) % N_CLK);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/cs_clk_event_sched.sv
// Mission-clock event scheduler: latches edge requests, grants round-robin, runs put then get
// per grant while freezing the granted clock. Optional stats outputs under CS_SCHED_STATS_EN.
module cs_clk_event_sched
  import cs_sched_pkg::*;
#(
  parameter int N_CLK    = 4,
  parameter int IDX_W    = 2,
  parameter int WDOG_MAX = WDOG_MAX_DEFAULT,
  parameter int WDOG_W   = WDOG_W_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CLK-1:0]         edge_req_i,
  input  logic                     put_en_i,
  input  logic                     get_en_i,
  cs_clk_event_sched_if.master     fringe,
  output logic [N_CLK-1:0]         rcv_valid_o,
  output logic [N_CLK-1:0]         freeze_clk_o,
  output logic                     overrun_o,
  output logic                     wdog_err_o,
  output logic                     busy_o,
  output cs_sched_state_e          dbg_state_o
`ifdef CS_SCHED_STATS_EN
  ,
  output logic [N_CLK-1:0][STATS_W-1:0] txn_cnt_o,
  output logic [WDOG_W-1:0]             max_wait_o
`endif
);

  cs_sched_state_e  state_q;
  logic [IDX_W-1:0] idx_q, rr_q;
  logic             get_en_q;
  logic [WDOG_W-1:0] wdog_q;
  logic             put_req_q, get_req_q, wdog_err_q, overrun_q;
  logic [N_CLK-1:0] freeze_q, rcv_q;
  logic [N_CLK-1:0] pend_q, pend_d, clr;
  logic [N_CLK-1:0] gnt_oh, idx_oh;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;

  cs_rr_arbiter #(
    .N_CLK (N_CLK),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (pend_q),
    .ptr_i (rr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign idx_oh = N_CLK'(1) << idx_q;

  // A new edge in the grant cycle keeps the event pending, so it is served again.
  assign clr    = (state_q == IDLE && gnt_vld) ? gnt_oh : '0;
  assign pend_d = (pend_q & ~clr) | edge_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (|(edge_req_i & pend_q & ~clr)) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rr_q       <= '0;
      get_en_q   <= 1'b0;
      wdog_q     <= '0;
      put_req_q  <= 1'b0;
      get_req_q  <= 1'b0;
      freeze_q   <= '0;
      rcv_q      <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      rcv_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            idx_q    <= gnt_idx;
            rr_q     <= IDX_W'(rr_next(int'(gnt_idx), N_CLK));
            get_en_q <= get_en_i;
            if (put_en_i) begin
              state_q   <= PUT;
              put_req_q <= 1'b1;
              freeze_q  <= gnt_oh;
            end else if (get_en_i) begin
              state_q   <= GET;
              get_req_q <= 1'b1;
              freeze_q  <= gnt_oh;
            end else begin
              state_q <= DONE;
              rcv_q   <= gnt_oh;
            end
          end
        end
        PUT: begin
          if (fringe.put_done_i) begin
            put_req_q <= 1'b0;
            if (get_en_q) begin
              state_q   <= GET;
              get_req_q <= 1'b1;
            end else begin
              state_q  <= DONE;
              rcv_q    <= idx_oh;
              freeze_q <= '0;
            end
          end
        end
        GET: begin
          wdog_q <= wdog_q + 1'b1;
          if (fringe.get_valid_i) begin
            state_q   <= DONE;
            get_req_q <= 1'b0;
            rcv_q     <= idx_oh;
            freeze_q  <= '0;
          end else if (wdog_q == WDOG_W'(WDOG_MAX - 1)) begin
            // Freeze is deliberately left on: the mission clock stays held until reset.
            state_q    <= ERR;
            get_req_q  <= 1'b0;
            wdog_err_q <= 1'b1;
          end
        end
        DONE: begin
          wdog_q  <= '0;
          state_q <= IDLE;
        end
        ERR:     state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fringe.put_req_o = put_req_q;
  assign fringe.put_idx_o = idx_q;
  assign fringe.get_req_o = get_req_q;
  assign fringe.get_idx_o = idx_q;
  assign rcv_valid_o      = rcv_q;
  assign freeze_clk_o     = freeze_q;
  assign overrun_o        = overrun_q;
  assign wdog_err_o       = wdog_err_q;
  assign busy_o           = (state_q != IDLE);
  assign dbg_state_o      = state_q;

`ifdef CS_SCHED_STATS_EN
  logic [N_CLK-1:0][STATS_W-1:0] txn_cnt_q;
  logic [WDOG_W-1:0]             max_wait_q;
  logic [WDOG_W-1:0]             wait_now;

  assign wait_now = wdog_q + 1'b1;

  // rcv_q is high exactly in the DONE cycle of a completed transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txn_cnt_q  <= '0;
      max_wait_q <= '0;
    end else begin
      for (int i = 0; i < N_CLK; i++) begin
        if (rcv_q[i] && txn_cnt_q[i] != {STATS_W{1'b1}}) txn_cnt_q[i] <= txn_cnt_q[i] + 1'b1;
      end
      if (state_q == GET && fringe.get_valid_i && wait_now > max_wait_q) max_wait_q <= wait_now;
    end
  end

  assign txn_cnt_o  = txn_cnt_q;
  assign max_wait_o = max_wait_q;
`endif

endmodule

// File: tb/tb_cs_clk_event_sched.sv
// Directed bench for cs_clk_event_sched: queue-based phase model checked every cycle,
// plus literal timing/order expectations per scenario.
`timescale 1ns/1ps
module tb_cs_clk_event_sched;
  import cs_sched_pkg::*;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int WMAX = 8;
  localparam int WW   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    edge_req;
  logic            put_en, get_en;
  logic [N-1:0]    rcv_valid, freeze;
  logic            overrun, wdog_err, busy;
  cs_sched_state_e dbg_state;
`ifdef CS_SCHED_STATS_EN
  logic [N-1:0][STATS_W-1:0] txn_cnt;
  logic [WW-1:0]             max_wait;
`endif

  cs_clk_event_sched_if #(.IDX_W(IW)) fr ();

  cs_clk_event_sched #(
    .N_CLK (N), .IDX_W (IW), .WDOG_MAX (WMAX), .WDOG_W (WW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .edge_req_i   (edge_req),
    .put_en_i     (put_en),
    .get_en_i     (get_en),
    .fringe       (fr),
    .rcv_valid_o  (rcv_valid),
    .freeze_clk_o (freeze),
    .overrun_o    (overrun),
    .wdog_err_o   (wdog_err),
    .busy_o       (busy),
    .dbg_state_o  (dbg_state)
`ifdef CS_SCHED_STATS_EN
    ,
    .txn_cnt_o    (txn_cnt),
    .max_wait_o   (max_wait)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  // Phase codes for the current transaction: 1 put, 2 get, 3 done, 4 error.
  bit m_ok = 1'b0;
  bit m_pend[N];
  int m_rr, m_cur, m_wcnt;
  bit m_ovr;
  int m_ph[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_ok = 1'b1;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_rr = 0; m_cur = 0; m_wcnt = 0; m_ovr = 1'b0;
        m_ph.delete();
      end else if (m_ok) begin
        int g;
        g = -1;
        if (m_ph.size() == 0) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (g < 0 && m_pend[j]) g = j;
          end
          if (g >= 0) begin
            m_cur = g;
            m_rr  = (g + 1) % N;
            if (put_en) m_ph.push_back(1);
            if (get_en) m_ph.push_back(2);
            m_ph.push_back(3);
          end
        end else begin
          case (m_ph[0])
            1: if (fr.put_done_i) void'(m_ph.pop_front());
            2: begin
              m_wcnt++;
              if (fr.get_valid_i) void'(m_ph.pop_front());
              else if (m_wcnt == WMAX) m_ph[0] = 4;
            end
            3: begin m_wcnt = 0; void'(m_ph.pop_front()); end
            default: ;
          endcase
        end
        for (int i = 0; i < N; i++) begin
          if (edge_req[i] && m_pend[i] && g != i) m_ovr = 1'b1;
          m_pend[i] = edge_req[i] || (m_pend[i] && g != i);
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int put_idx_log[$], put_cyc_log[$], get_cyc_log[$], rcv_vec_log[$], rcv_cyc_log[$];
  int get_hi, freeze_hi;
  bit prev_put = 1'b0, prev_get = 1'b0;

  initial begin
    int h;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        h  = (m_ph.size() > 0) ? m_ph[0] : 0;
        oh = N'(1) << m_cur;
        chk("put_req", int'(fr.put_req_o), int'(h == 1));
        chk("get_req", int'(fr.get_req_o), int'(h == 2));
        if (h == 1) chk("put_idx", int'(fr.put_idx_o), m_cur);
        if (h == 2) chk("get_idx", int'(fr.get_idx_o), m_cur);
        chk("rcv_valid", int'(rcv_valid), (h == 3) ? int'(oh) : 0);
        chk("freeze", int'(freeze), (h == 1 || h == 2 || h == 4) ? int'(oh) : 0);
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("wdog_err", int'(wdog_err), int'(h == 4));
        chk("busy", int'(busy), int'(h != 0));
      end
      if (fr.put_req_o && !prev_put) begin
        put_idx_log.push_back(int'(fr.put_idx_o));
        put_cyc_log.push_back(cyc);
      end
      if (fr.get_req_o && !prev_get) get_cyc_log.push_back(cyc);
      if (fr.get_req_o) get_hi++;
      if (freeze != '0) freeze_hi++;
      if (rcv_valid != '0) begin
        rcv_vec_log.push_back(int'(rcv_valid));
        rcv_cyc_log.push_back(cyc);
      end
      prev_put = fr.put_req_o;
      prev_get = fr.get_req_o;
    end
  end

  // ---------------- transport responder ----------------
  int put_lat = 0, get_lat = 0;
  bit noise = 1'b0;

  initial begin
    int pc, gc;
    pc = 0; gc = 0;
    fr.put_done_i  = 1'b0;
    fr.get_valid_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pc = fr.put_req_o ? pc + 1 : 0;
      gc = fr.get_req_o ? gc + 1 : 0;
      fr.put_done_i  = noise || (fr.put_req_o && pc > put_lat);
      fr.get_valid_i = noise || (fr.get_req_o && get_lat >= 0 && gc > get_lat);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] vec, output int c);
    edge_req = vec;
    c = cyc;
    tick(1);
    edge_req = '0;
  endtask

  task automatic clear_logs();
    put_idx_log.delete(); put_cyc_log.delete(); get_cyc_log.delete();
    rcv_vec_log.delete(); rcv_cyc_log.delete();
    get_hi = 0; freeze_hi = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c, c2;
    rst = 1'b1; edge_req = '0; put_en = 1'b1; get_en = 1'b1;
    tick(3);
    chk("rst_put_req", int'(fr.put_req_o), 0);
    chk("rst_get_req", int'(fr.get_req_o), 0);
    chk("rst_freeze", int'(freeze), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wdog_err", int'(wdog_err), 0);
    rst = 1'b0;

    // single event, best-case transport
    clear_logs();
    pulse(4'b0001, c);
    tick(10);
    chk("t1_put_count", put_cyc_log.size(), 1);
    chk("t1_put_lat", qget(put_cyc_log, 0) - c, 2);
    chk("t1_put_idx", qget(put_idx_log, 0), 0);
    chk("t1_get_lat", qget(get_cyc_log, 0) - c, 3);
    chk("t1_rcv_lat", qget(rcv_cyc_log, 0) - c, 4);
    chk("t1_rcv_vec", qget(rcv_vec_log, 0), 1);
    chk("t1_rcv_count", rcv_vec_log.size(), 1);
    chk("t1_busy_after", int'(busy), 0);

    // same-cycle edges served in rr order, pointer wraps back to 0
    do_reset();
    clear_logs();
    pulse(4'b1011, c);
    tick(16);
    chk("t2_count", put_idx_log.size(), 3);
    chk("t2_idx0", qget(put_idx_log, 0), 0);
    chk("t2_idx1", qget(put_idx_log, 1), 1);
    chk("t2_idx2", qget(put_idx_log, 2), 3);
    chk("t2_cyc0", qget(put_cyc_log, 0) - c, 2);
    chk("t2_cyc1", qget(put_cyc_log, 1) - c, 6);
    chk("t2_cyc2", qget(put_cyc_log, 2) - c, 10);
    chk("t2_overrun", int'(overrun), 0);
    clear_logs();
    pulse(4'b1001, c);
    tick(12);
    chk("t2_wrap_first", qget(put_idx_log, 0), 0);
    chk("t2_wrap_second", qget(put_idx_log, 1), 3);

    // double edge on idx 2 while it waits behind a slow put
    do_reset();
    clear_logs();
    put_lat = 4;
    pulse(4'b0001, c);
    tick(1);
    pulse(4'b0100, c2);
    pulse(4'b0100, c2);
    tick(30);
    put_lat = 0;
    chk("t3_count", put_idx_log.size(), 2);
    chk("t3_first", qget(put_idx_log, 0), 0);
    chk("t3_second", qget(put_idx_log, 1), 2);
    chk("t3_overrun", int'(overrun), 1);
    chk("t3_rcv_count", rcv_vec_log.size(), 2);

    // edge on idx 1 during its own GET is served again right after DONE
    do_reset();
    clear_logs();
    get_lat = 4;
    pulse(4'b0010, c);
    tick(3);
    pulse(4'b0010, c2);
    tick(20);
    get_lat = 0;
    chk("t4_rcv_count", rcv_vec_log.size(), 2);
    chk("t4_rcv0", qget(rcv_vec_log, 0), 2);
    chk("t4_rcv1", qget(rcv_vec_log, 1), 2);
    chk("t4_second_put", qget(put_cyc_log, 1) - c, 10);
    chk("t4_overrun", int'(overrun), 0);

    // stray answers while idle, then get-only and no-phase transactions
    do_reset();
    clear_logs();
    noise = 1'b1;
    tick(3);
    noise = 1'b0;
    tick(1);
    chk("t6_noise_busy", int'(busy), 0);
    chk("t6_noise_put", put_cyc_log.size(), 0);
    put_en = 1'b0;
    clear_logs();
    pulse(4'b0100, c);
    tick(8);
    chk("t6a_put_count", put_cyc_log.size(), 0);
    chk("t6a_get_lat", qget(get_cyc_log, 0) - c, 2);
    chk("t6a_rcv_lat", qget(rcv_cyc_log, 0) - c, 3);
    chk("t6a_rcv_vec", qget(rcv_vec_log, 0), 4);
    get_en = 1'b0;
    clear_logs();
    pulse(4'b1000, c);
    tick(8);
    chk("t6b_put_count", put_cyc_log.size(), 0);
    chk("t6b_get_count", get_cyc_log.size(), 0);
    chk("t6b_rcv_count", rcv_vec_log.size(), 1);
    chk("t6b_rcv_lat", qget(rcv_cyc_log, 0) - c, 2);
    chk("t6b_rcv_vec", qget(rcv_vec_log, 0), 8);
    chk("t6b_freeze_hi", freeze_hi, 0);
    put_en = 1'b1; get_en = 1'b1;

    // watchdog timeout into ERR, then reset recovery
    do_reset();
    clear_logs();
    get_lat = -1;
    pulse(4'b0010, c);
    tick(14);
    chk("t5_get_cycles", get_hi, 8);
    chk("t5_wdog_err", int'(wdog_err), 1);
    chk("t5_freeze", int'(freeze), 2);
    chk("t5_put_req", int'(fr.put_req_o), 0);
    chk("t5_get_req", int'(fr.get_req_o), 0);
    chk("t5_busy", int'(busy), 1);
    chk("t5_state", int'(dbg_state), int'(ERR));
    pulse(4'b0001, c2);
    tick(5);
    chk("t5_err_terminal", put_cyc_log.size(), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    get_lat = 0;
    chk("t5_rst_wdog_err", int'(wdog_err), 0);
    chk("t5_rst_freeze", int'(freeze), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_overrun", int'(overrun), 0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
